// File: rtl/riscv_fetch_unit.sv
// Decoupled instruction fetch: credit-limited word requests, in-order responses into a prefetch FIFO.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned redirect presents a held fault NOP instead of fetching.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault
);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   fifo_word_q [FIFO_DEPTH];
  logic          req_fire, push, pop, fifo_valid, fault_hold;
  logic [31:0]   redirect_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault_hold_q, fault_hold_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  assign fault_hold = fault_hold_q;

  always_comb begin
    fault_hold_d = fault_hold_q;
    fault_pc_d   = fault_pc_q;
    if (redirect_valid) begin
      fault_hold_d = |redirect_pc[1:0];
      fault_pc_d   = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_hold_q <= 1'b0;
      fault_pc_q   <= '0;
    end else begin
      fault_hold_q <= fault_hold_d;
      fault_pc_q   <= fault_pc_d;
    end
  end
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign fault_hold    = 1'b0;
`endif

  assign redirect_tgt  = {redirect_pc[31:2], 2'b00};
  assign fifo_valid    = (count_q != '0);
  assign mem_req_valid = !rst && !redirect_valid && !fault_hold &&
                         (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_C);
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign push          = mem_rsp_valid && !redirect_valid && (drop_q == '0);
  assign pop           = fifo_valid && instr_ready && !redirect_valid;

  always_comb begin
    instr_valid = fifo_valid;
    instr       = fifo_valid ? fifo_word_q[rd_ptr_q] : '0;
    instr_pc    = fifo_valid ? fifo_pc_q[rd_ptr_q] : '0;
    instr_fault = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    if (fault_hold) begin
      instr_valid = 1'b1;
      instr       = NOP;
      instr_pc    = fault_pc_q;
      instr_fault = 1'b1;
    end
`endif
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(mem_rsp_valid);
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      // outst_q already includes responses marked for drop, so this discards every one still in flight.
      drop_d     = outst_q - CW'(mem_rsp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (mem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
      fifo_word_q[wr_ptr_q] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit with a latency-configurable in-order memory returning addr^A5A5_0000.
module tb_riscv_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned lat   = 1;

  always #5 clk = ~clk;

  riscv_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_fault    (instr_fault)
  );

  // Memory: a request accepted in cycle N answers in cycle N+lat.
  logic [31:0] q_addr [$];
  int unsigned q_due  [$];
  int unsigned mcyc = 0;

  always @(negedge clk) begin
    #3;
    mcyc++;
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        q_addr.push_back(mem_req_addr);
        q_due.push_back(mcyc + lat);
      end
      if (q_due.size() != 0 && q_due[0] <= mcyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = q_addr[0] ^ 32'hA5A5_0000;
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Leaves the bench in the first cycle after rst deasserts.
  task automatic do_reset(input int unsigned l, input logic rdy, input logic ird);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();
    lat           = l;
    mem_req_ready = rdy;
    instr_ready   = ird;
    chk_b("rst_req_valid",   mem_req_valid, 1'b0);
    chk_w("rst_req_addr",    mem_req_addr,  32'h0000_0000);
    chk_b("rst_instr_valid", instr_valid,   1'b0);
    chk_w("rst_instr",       instr,         32'h0000_0000);
    chk_w("rst_instr_pc",    instr_pc,      32'h0000_0000);
    chk_b("rst_instr_fault", instr_fault,   1'b0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] t1_pc [4];
    logic [31:0] t1_w  [4];
    t1_pc = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
    t1_w  = '{32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008, 32'hA5A5_000C};

    // Streaming, latency 1, consumer always ready.
    do_reset(1, 1'b1, 1'b1);
    chk_b("t1_first_req_valid", mem_req_valid, 1'b1);
    chk_w("t1_first_req_addr",  mem_req_addr,  32'h0000_0000);
    tick();
    chk_b("t1_no_bypass", instr_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_b("t1_valid", instr_valid, 1'b1);
      chk_w("t1_pc",    instr_pc,    t1_pc[i]);
      chk_w("t1_word",  instr,       t1_w[i]);
    end

    // Consumer stalled: credit limits requests to 0..12.
    do_reset(1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      chk_b("t2_req_valid", mem_req_valid, 1'b1);
      chk_w("t2_req_addr",  mem_req_addr,  t1_pc[i]);
    end
    tick();
    chk_b("t2_credit_stop_c4", mem_req_valid, 1'b0);
    tick();
    chk_b("t2_credit_stop_c5", mem_req_valid, 1'b0);
    chk_w("t2_head_pc",        instr_pc,      32'h0000_0000);
    chk_w("t2_head_word",      instr,         32'hA5A5_0000);
    tick();
    chk_b("t2_credit_stop_c6", mem_req_valid, 1'b0);
    instr_ready = 1'b1;
    tick();
    chk_b("t2_after_pop_valid", mem_req_valid, 1'b1);
    chk_w("t2_after_pop_addr",  mem_req_addr,  32'h0000_0010);

    // Memory not ready for 5 cycles: address held.
    do_reset(1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) tick();
      chk_b("t3_hold_valid", mem_req_valid, 1'b1);
      chk_w("t3_hold_addr",  mem_req_addr,  32'h0000_0000);
    end
    tick();
    mem_req_ready = 1'b1;
    chk_w("t3_ready_addr", mem_req_addr, 32'h0000_0000);
    tick();
    chk_w("t3_next_addr", mem_req_addr, 32'h0000_0004);
    tick();
    chk_w("t3_addr_8",    mem_req_addr, 32'h0000_0008);
    chk_b("t3_valid",     instr_valid,  1'b1);
    chk_w("t3_first_pc",  instr_pc,     32'h0000_0000);

    // Three in flight at latency 4, redirect to 0x100.
    do_reset(4, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    chk_b("t4_redirect_no_req", mem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk_b("t4_req_valid",   mem_req_valid, 1'b1);
    chk_w("t4_req_addr",    mem_req_addr,  32'h0000_0100);
    chk_b("t4_flush_empty", instr_valid,   1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_b("t4_dropped", instr_valid, 1'b0);
    end
    tick();
    chk_b("t4_valid", instr_valid, 1'b1);
    chk_w("t4_pc",    instr_pc,    32'h0000_0100);
    chk_w("t4_word",  instr,       32'hA5A5_0100);

    // Redirect coinciding with a response and a pop.
    do_reset(1, 1'b1, 1'b1);
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    chk_b("t5_head_present", instr_valid,   1'b1);
    chk_b("t5_redirect_no_req", mem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk_b("t5_empty",     instr_valid,   1'b0);
    chk_b("t5_req_valid", mem_req_valid, 1'b1);
    chk_w("t5_req_addr",  mem_req_addr,  32'h0000_0200);
    tick();
    chk_b("t5_still_empty", instr_valid, 1'b0);
    tick();
    chk_w("t5_pc", instr_pc, 32'h0000_0200);

    // Misaligned redirect to 0x102.
    do_reset(1, 1'b1, 1'b1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    #1;
    chk_b("t6_redirect_no_req", mem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      if (i != 0) tick();
      chk_b("t6_fault_no_req", mem_req_valid, 1'b0);
      chk_b("t6_fault_valid",  instr_valid,   1'b1);
      chk_b("t6_fault_flag",   instr_fault,   1'b1);
      chk_w("t6_fault_instr",  instr,         32'h0000_0013);
      chk_w("t6_fault_pc",     instr_pc,      32'h0000_0102);
    end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    chk_b("t6_resume_redirect_no_req", mem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk_b("t6_resume_req_valid", mem_req_valid, 1'b1);
    chk_w("t6_resume_req_addr",  mem_req_addr,  32'h0000_0200);
    chk_b("t6_resume_empty",     instr_valid,   1'b0);
    chk_b("t6_resume_no_fault",  instr_fault,   1'b0);
    tick();
    tick();
    chk_w("t6_resume_pc",    instr_pc,    32'h0000_0200);
    chk_w("t6_resume_word",  instr,       32'hA5A5_0200);
    chk_b("t6_resume_fault", instr_fault, 1'b0);
`else
    chk_b("t6_align_req_valid", mem_req_valid, 1'b1);
    chk_w("t6_align_req_addr",  mem_req_addr,  32'h0000_0100);
    chk_b("t6_align_empty",     instr_valid,   1'b0);
    chk_b("t6_align_no_fault",  instr_fault,   1'b0);
    tick();
    tick();
    chk_w("t6_align_pc",    instr_pc,    32'h0000_0100);
    chk_w("t6_align_word",  instr,       32'hA5A5_0100);
    chk_b("t6_align_fault", instr_fault, 1'b0);
`endif

    // Address wrap at 2^32.
    do_reset(1, 1'b1, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1;
    chk_b("t7_redirect_no_req", mem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk_w("t7_addr_top", mem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk_w("t7_addr_wrap", mem_req_addr, 32'h0000_0000);
    tick();
    chk_w("t7_pc_top",    instr_pc, 32'hFFFF_FFFC);
    chk_w("t7_word_top",  instr,    32'h5A5A_FFFC);
    tick();
    chk_w("t7_pc_wrap",   instr_pc, 32'h0000_0000);
    chk_w("t7_word_wrap", instr,    32'hA5A5_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
